// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller: forwarding
// select codes, branch-resolve stage codes and the shadow-slot records.
package mips_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int BR_ID  = 1;
  localparam int BR_EX  = 2;
  localparam int BR_MEM = 3;

  // Slots carry register numbers at a fixed maximum width; narrower
  // REG_AW values are zero-extended on entry, so REG_AW must be <= RA_MAX.
  localparam int RA_MAX = 8;
  typedef logic [RA_MAX-1:0] reg_addr_t;

  typedef struct packed {
    logic      v;
    reg_addr_t rs;
    reg_addr_t rt;
    logic      uses_rs;
    logic      uses_rt;
    reg_addr_t dst;
    logic      rw;
    logic      mr;
  } ex_slot_t;

  typedef struct packed {
    logic      v;
    reg_addr_t dst;
    logic      rw;
    logic      mr;
  } mem_slot_t;

  typedef struct packed {
    logic      v;
    reg_addr_t dst;
    logic      rw;
  } wb_slot_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding priority: EX/MEM result beats MEM/WB value,
// R0 never forwards.
module fwd_sel
  import mips_pkg::*;
(
  input  logic       uses,
  input  reg_addr_t  src,
  input  mem_slot_t  mem_s,
  input  wb_slot_t   wb_s,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (uses && (src != '0)) begin
      // A load in MEM has no ALU result worth forwarding; its data
      // arrives one stage later through MEM/WB.
      if (mem_s.v && mem_s.rw && !mem_s.mr && (mem_s.dst == src))
        sel = FWD_EXMEM;
      else if (wb_s.v && wb_s.rw && (wb_s.dst == src))
        sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage 16-bit MIPS pipeline.
// Optional perf counters are built only when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int BR_STAGE = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              br_taken,
  input  logic              ext_stall,
  output logic              stall_pc_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              flush_exmem,
  output logic              freeze_all,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ex_slot_t   ex_q,  ex_d;
  mem_slot_t  mem_q, mem_d;
  wb_slot_t   wb_q,  wb_d;
  reg_addr_t  id_rs_x, id_rt_x, id_dst_x;
  logic       accept_br, load_use, lu_fire;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign id_rs_x  = reg_addr_t'(id_rs);
  assign id_rt_x  = reg_addr_t'(id_rt);
  assign id_dst_x = reg_addr_t'(id_dst);

  always_comb begin
    accept_br = br_taken & ~ext_stall;
    load_use  = id_valid & ex_q.v & ex_q.mr & ex_q.rw & (ex_q.dst != '0) &
                ((id_uses_rs & (id_rs_x == ex_q.dst)) |
                 (id_uses_rt & (id_rt_x == ex_q.dst)));
    // A taken branch discards the dependent instruction, so no stall.
    lu_fire   = load_use & ~accept_br & ~ext_stall;
  end

  fwd_sel u_fwd_a (
    .uses  (ex_q.v & ex_q.uses_rs),
    .src   (ex_q.rs),
    .mem_s (mem_q),
    .wb_s  (wb_q),
    .sel   (fwd_a_raw)
  );

  fwd_sel u_fwd_b (
    .uses  (ex_q.v & ex_q.uses_rt),
    .src   (ex_q.rt),
    .mem_s (mem_q),
    .wb_s  (wb_q),
    .sel   (fwd_b_raw)
  );

  always_comb begin
    stall_pc_ifid = 1'b0;
    bubble_idex   = 1'b0;
    flush_ifid    = 1'b0;
    flush_exmem   = 1'b0;
    freeze_all    = 1'b0;
    fwd_a         = FWD_RF;
    fwd_b         = FWD_RF;
    if (!rst) begin
      stall_pc_ifid = lu_fire;
      bubble_idex   = lu_fire | (accept_br & (BR_STAGE >= BR_EX));
      flush_ifid    = accept_br;
      flush_exmem   = accept_br & (BR_STAGE == BR_MEM);
      freeze_all    = ext_stall;
      fwd_a         = fwd_a_raw;
      fwd_b         = fwd_b_raw;
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!ext_stall) begin
      wb_d  = '{v: mem_q.v, dst: mem_q.dst, rw: mem_q.rw};
      mem_d = '{v: ex_q.v, dst: ex_q.dst, rw: ex_q.rw, mr: ex_q.mr};
      ex_d  = '{v: id_valid, rs: id_rs_x, rt: id_rt_x,
                uses_rs: id_uses_rs, uses_rt: id_uses_rt,
                dst: id_dst_x, rw: id_reg_write, mr: id_mem_read};
      if (lu_fire || (accept_br && (BR_STAGE >= BR_EX)))
        ex_d = '0;
      if (accept_br && (BR_STAGE == BR_MEM))
        mem_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu_fire && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (accept_br && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = rst ? '0 : stall_cnt_q;
  assign flush_cnt = rst ? '0 : flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then random stimulus against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int BR = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic [2:0]    id_rs = '0, id_rt = '0, id_dst = '0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic          br_taken = 1'b0, ext_stall = 1'b0;
  logic          stall_pc_ifid, bubble_idex, flush_ifid, flush_exmem, freeze_all;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_AW(3), .BR_STAGE(BR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .br_taken(br_taken), .ext_stall(ext_stall),
    .stall_pc_ifid(stall_pc_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .flush_exmem(flush_exmem), .freeze_all(freeze_all),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model: the instructions occupying EX (0), MEM (1) and WB (2).
  int m_v[3], m_rs[3], m_rt[3], m_urs[3], m_urt[3], m_dst[3], m_rw[3], m_mr[3];
  int m_scnt = 0, m_fcnt = 0;

  initial for (int i = 0; i < 3; i++) begin
    m_v[i] = 0; m_rs[i] = 0; m_rt[i] = 0; m_urs[i] = 0;
    m_urt[i] = 0; m_dst[i] = 0; m_rw[i] = 0; m_mr[i] = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A dependent ID instruction reads a load's result that is still in EX.
  function automatic logic m_load_use();
    if (!id_valid || m_v[0] == 0 || m_mr[0] == 0 || m_rw[0] == 0 || m_dst[0] == 0)
      return 1'b0;
    return (id_uses_rs && int'(id_rs) == m_dst[0]) || (id_uses_rt && int'(id_rt) == m_dst[0]);
  endfunction

  function automatic logic [1:0] m_fwd(input int uses, input int r);
    if (m_v[0] == 0 || uses == 0 || r == 0) return 2'b00;
    if (m_v[1] != 0 && m_rw[1] != 0 && m_mr[1] == 0 && m_dst[1] == r) return 2'b10;
    if (m_v[2] != 0 && m_rw[2] != 0 && m_dst[2] == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat_inc(input int c);
    return (c < (1 << CW) - 1) ? c + 1 : c;
  endfunction

  always @(posedge clk) begin : model_step
    logic taken, stall;
    taken = br_taken && !ext_stall;
    stall = m_load_use() && !taken && !ext_stall;
    if (rst) begin
      for (int i = 0; i < 3; i++) m_v[i] = 0;
      m_scnt = 0;
      m_fcnt = 0;
    end else if (!ext_stall) begin
      if (stall) m_scnt = sat_inc(m_scnt);
      if (taken) m_fcnt = sat_inc(m_fcnt);
      for (int i = 2; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_rs[i] = m_rs[i-1]; m_rt[i] = m_rt[i-1];
        m_urs[i] = m_urs[i-1]; m_urt[i] = m_urt[i-1]; m_dst[i] = m_dst[i-1];
        m_rw[i] = m_rw[i-1]; m_mr[i] = m_mr[i-1];
      end
      m_v[0] = int'(id_valid); m_rs[0] = int'(id_rs); m_rt[0] = int'(id_rt);
      m_urs[0] = int'(id_uses_rs); m_urt[0] = int'(id_uses_rt);
      m_dst[0] = int'(id_dst); m_rw[0] = int'(id_reg_write); m_mr[0] = int'(id_mem_read);
      if (stall || (taken && BR >= 2)) m_v[0] = 0;
      if (taken && BR == 3) m_v[1] = 0;
    end
  end

  always @(negedge clk) begin : compare
    logic taken, stall;
    logic [1:0] ea, eb;
    int es, ef;
    if (rst) begin
      chk("m_stall", stall_pc_ifid, 0); chk("m_bubble", bubble_idex, 0);
      chk("m_flush_ifid", flush_ifid, 0); chk("m_flush_exmem", flush_exmem, 0);
      chk("m_freeze", freeze_all, 0); chk("m_fwd_a", fwd_a, 0); chk("m_fwd_b", fwd_b, 0);
      chk("m_stall_cnt", stall_cnt, 0); chk("m_flush_cnt", flush_cnt, 0);
    end else begin
      taken = br_taken && !ext_stall;
      stall = m_load_use() && !taken && !ext_stall;
      ea = m_fwd(m_urs[0], m_rs[0]);
      eb = m_fwd(m_urt[0], m_rt[0]);
`ifdef HAZ_PERF_EN
      es = m_scnt; ef = m_fcnt;
`else
      es = 0; ef = 0;
`endif
      chk("m_stall", stall_pc_ifid, stall);
      chk("m_bubble", bubble_idex, !ext_stall && (stall || (taken && BR >= 2)));
      chk("m_flush_ifid", flush_ifid, taken);
      chk("m_flush_exmem", flush_exmem, taken && BR == 3);
      chk("m_freeze", freeze_all, ext_stall);
      chk("m_fwd_a", fwd_a, ea);
      chk("m_fwd_b", fwd_b, eb);
      chk("m_stall_cnt", stall_cnt, es);
      chk("m_flush_cnt", flush_cnt, ef);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                     input logic urs, input logic urt, input logic [2:0] dst,
                     input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dst = dst; id_reg_write = rw; id_mem_read = mr;
  endtask

  initial begin
    put(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); #2;
    chk("rst_stall", stall_pc_ifid, 0);
    chk("rst_fwd_a", fwd_a, 0);
    tick();
    rst = 1'b0;

    // lw r3 then add r4 <- r3 + r5
    put(1, 1, 0, 1, 0, 3, 1, 1); tick();
    put(1, 3, 5, 1, 1, 4, 1, 0); #2;
    chk("lu_stall", stall_pc_ifid, 1);
    chk("lu_bubble", bubble_idex, 1);
    tick(); #2;
    chk("lu_once_stall", stall_pc_ifid, 0);
    chk("lu_once_bubble", bubble_idex, 0);
    tick();
    put(1, 1, 1, 1, 1, 2, 1, 0); #2;               // next: add r2
    chk("lu_fwd_a_wb", fwd_a, 2'b01);
    chk("lu_fwd_b_rf", fwd_b, 2'b00);

    // back-to-back ALU on r2
    tick();
    put(1, 2, 1, 1, 1, 6, 1, 0); #2;               // sub r6 <- r2
    chk("alu_no_stall", stall_pc_ifid, 0);
    tick();
    put(1, 2, 0, 1, 0, 7, 1, 0); #2;               // third reader of r2
    chk("alu_fwd_exmem", fwd_a, 2'b10);
    tick();
    put(1, 1, 1, 1, 1, 2, 1, 0); #2;               // add r2 again
    chk("alu_fwd_memwb", fwd_a, 2'b01);
    tick();
    put(1, 1, 1, 1, 1, 2, 1, 0);                   // and once more
    tick();
    put(1, 2, 0, 1, 0, 5, 1, 0);                   // reader of r2
    tick();
    put(1, 1, 0, 1, 0, 5, 1, 1); #2;               // next: lw r5
    chk("alu_fwd_prio", fwd_a, 2'b10);

    // taken branch overriding a pending load-use
    tick();
    put(1, 5, 0, 1, 0, 3, 1, 0); br_taken = 1'b1; #2;
    chk("br_flush_ifid", flush_ifid, 1);
    chk("br_bubble", bubble_idex, 1);
    chk("br_flush_exmem", flush_exmem, 1);
    chk("br_no_stall", stall_pc_ifid, 0);
    tick();
    br_taken = 1'b0; #2;
    chk("br_load_gone", stall_pc_ifid, 0);
    tick(); #2;
    chk("br_slots_clear", fwd_a, 2'b00);

    // R0 never hazards or forwards
    put(1, 1, 0, 1, 0, 0, 1, 1); tick();           // lw r0
    put(1, 0, 0, 1, 1, 0, 1, 0); #2;               // add r0 <- r0
    chk("r0_no_stall", stall_pc_ifid, 0);
    tick();
    put(1, 0, 0, 1, 1, 4, 1, 0); tick(); #2;
    chk("r0_fwd_a", fwd_a, 2'b00);
    chk("r0_fwd_b", fwd_b, 2'b00);

    // external stall holding a pending load-use
    put(1, 1, 0, 1, 0, 3, 1, 1); tick();
    put(1, 3, 0, 1, 0, 4, 1, 0); ext_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("ext_freeze", freeze_all, 1);
      chk("ext_no_stall", stall_pc_ifid, 0);
      chk("ext_no_bubble", bubble_idex, 0);
      tick();
    end
    ext_stall = 1'b0; #2;
    chk("ext_release_stall", stall_pc_ifid, 1);
    chk("ext_release_bubble", bubble_idex, 1);
    tick(); #2;
    chk("ext_stall_once", stall_pc_ifid, 0);
`ifdef HAZ_PERF_EN
    chk("perf_stall_cnt", stall_cnt, 2);
    chk("perf_flush_cnt", flush_cnt, 1);
`else
    chk("perf_stall_cnt", stall_cnt, 0);
    chk("perf_flush_cnt", flush_cnt, 0);
`endif

    // reset right after a taken branch
    put(0, 0, 0, 0, 0, 0, 0, 0); br_taken = 1'b1;
    tick();
    br_taken = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; #2;
    chk("rstbr_flush_ifid", flush_ifid, 0);
    chk("rstbr_bubble", bubble_idex, 0);
    chk("rstbr_fwd_a", fwd_a, 0);
    chk("rstbr_stall_cnt", stall_cnt, 0);
    chk("rstbr_flush_cnt", flush_cnt, 0);

    // randomized traffic on a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst       = ($urandom_range(0, 99) == 0);
      ext_stall = ($urandom_range(0, 6) == 0);
      br_taken  = ($urandom_range(0, 9) == 0);
      put($urandom_range(0, 7) != 0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    end
    tick();
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage 16-bit MIPS pipeline (Fetch, Decode, Execute, Memory, Writeback).
- Keeps its own shadow record of the destination register, RegWrite and MemRead for the instructions in ID/EX, EX/MEM and MEM/WB.
- Drives load-use stalls, taken-branch flushes and EX-stage operand forwarding selects.
- Sits beside the pipeline registers in the MIPS top and gates their write-enable and clear inputs.

Parameters:
- REG_AW, 3, register-address width (8 GPRs; R0 reads as zero).
- BR_STAGE, 3, stage that resolves branches: 1=ID, 2=EX, 3=MEM. Legal range 1..3.
- CNT_W, 16, width of the performance counters (used only with HAZ_PERF_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  ID source register A (instruction[12:10]).
- id_rt  in  REG_AW  ID source register B (instruction[9:7]).
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_dst  in  REG_AW  ID destination register, already RegDst-resolved.
- id_reg_write  in  1  ID RegWrite.
- id_mem_read  in  1  ID MemRead.
- br_taken  in  1  branch taken, asserted from stage BR_STAGE.
- ext_stall  in  1  freeze the whole pipeline (memory busy).
- stall_pc_ifid  out  1  hold PC and IF/ID.
- bubble_idex  out  1  load a NOP (all controls 0) into ID/EX.
- flush_ifid  out  1  clear IF/ID.
- flush_exmem  out  1  clear EX/MEM controls.
- freeze_all  out  1  hold every pipeline register.
- fwd_a  out  2  EX operand A source: 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB writeback value.
- fwd_b  out  2  EX operand B source, same encoding as fwd_a.
- stall_cnt  out  CNT_W  load-use stall cycles (HAZ_PERF_EN only).
- flush_cnt  out  CNT_W  taken-branch flush events (HAZ_PERF_EN only).

Behaviour:
- Shadow slots:
  - EX slot {v, rs, rt, uses_rs, uses_rt, dst, rw, mr}; MEM slot {v, dst, rw, mr}; WB slot {v, dst, rw}.
  - Slots update on each rising clk edge unless freeze_all is high.
- Reset: all slots invalid. All outputs 0, counters 0. Reset mid-stall or mid-flush takes effect on the next edge; nothing carries over.
- Load-use (combinational in the current cycle): asserted when id_valid, EX.v, EX.mr and EX.rw are all true, EX.dst≠0, and (id_uses_rs and id_rs=EX.dst, or id_uses_rt and id_rt=EX.dst).
  - Response: stall_pc_ifid=1 and bubble_idex=1.
  - At the next edge EX gets invalid, MEM<=EX, and the ID instruction is not consumed.
  - Exactly one bubble; the load then sits in MEM/WB for forwarding.
- Normal advance: EX<=ID fields (v=id_valid), MEM<=EX, WB<=MEM.
- Taken branch:
  - flush_ifid=1 always.
  - bubble_idex=1 if BR_STAGE≥2.
  - flush_exmem=1 if BR_STAGE=3.
  - Flushed shadow slots go invalid at the edge.
  - Flush overrides load-use: stall_pc_ifid=0 when br_taken=1.
- Forwarding, per operand x∈{rs,rt}, valid only if EX.uses_x:
  - Select 10 if MEM.v, MEM.rw, MEM.dst≠0 and MEM.dst=EX.x. MEM.mr=1 never matches here, because load-use guarantees separation.
  - Otherwise select 01 if WB.v, WB.rw, WB.dst≠0 and WB.dst=EX.x.
  - Otherwise 00. EX/MEM has priority over MEM/WB.
- R0 never causes a hazard or a forward.
- ext_stall:
  - freeze_all=1, and all other outputs are forced 0 except fwd_a/fwd_b, which stay valid.
  - Slots and counters hold.
  - br_taken during ext_stall is ignored. The source stage must hold it until ext_stall drops.
- Register-file write-before-read in the same cycle is the register file's job. No third bypass.

Optional Feature:
- HAZ_PERF_EN defined:
  - stall_cnt increments on each load-use cycle that is not frozen or flushed.
  - flush_cnt increments on each accepted br_taken.
  - Both saturate at all-ones; rst clears them.
- HAZ_PERF_EN undefined: both counters are absent from the logic and the ports are tied to 0.

Decomposition:
- Shared package mips_pkg holds:
  - FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01.
  - BR_ID/BR_EX/BR_MEM stage codes.
  - The shadow-slot struct typedef.
- One natural sub-module, fwd_sel: the per-operand priority comparator, instantiated twice (rs, rt).

Test Plan:
- Load-use: lw r3 in EX (mr=1, dst=3), ID add reads rs=3 → stall_pc_ifid=1 and bubble_idex=1 for exactly 1 cycle; next cycle fwd_a=01.
- Back-to-back ALU: add r2 then sub reading r2 → no stall, fwd_a=10. A third instruction reading r2 → fwd_a=01. When both MEM and WB write r2 → 10.
- BR_STAGE=3, br_taken=1 with a load-use pending → flush_ifid, bubble_idex and flush_exmem all 1, stall_pc_ifid=0; the 3 slots go invalid.
- R0 destination: lw r0 followed by a reader of r0 → no stall, fwd=00.
- ext_stall held 4 cycles during a pending load-use → freeze_all=1 and stall outputs 0. On release the stall fires once; stall_cnt=1 with HAZ_PERF_EN.
- rst asserted in the cycle after a taken branch → all outputs 0 next cycle, slots invalid, counters 0.
